// File: rtl/sync_fifo.sv
// Single-clock FIFO with a built-in fixed-rate drain: one word is popped every
// READ_DIV cycles while data is held, presented on a registered data_out.
module sync_fifo #(
  parameter int SIZE     = 8,
  parameter int DEPTH    = 4,
  parameter int READ_DIV = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] data_in,
  input  logic            valid_write,
  output logic [SIZE-1:0] data_out,
  output logic            f_flag,
  output logic            e_flag,
  output logic            almost_full_flag
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DIV_W = (READ_DIV > 1) ? $clog2(READ_DIV) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(DEPTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(READ_DIV - 1);

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  logic [SIZE-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [CNT_W-1:0] count;
  logic [DIV_W-1:0] div;

  logic tick;
  logic pop;
  logic push;

  assign tick = (div == DIV_LAST);
  assign pop  = tick && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = valid_write && ((count != CNT_FULL) || pop);

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wp] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      div      <= '0;
      data_out <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (pop) begin
        data_out <= mem[rp];
        rp       <= ptr_next(rp);
      end
      if (push) begin
        wp <= ptr_next(wp);
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign e_flag           = (count == '0);
  assign f_flag           = (count == CNT_FULL);
  assign almost_full_flag = (count >= CNT_AFULL);

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue model predicts drain ticks, accepted
// words and flags; every popped word is compared against the queue head.
module tb_sync_fifo;

  localparam int SIZE     = 8;
  localparam int DEPTH    = 4;
  localparam int READ_DIV = 5;

  logic            clk;
  logic            rst;
  logic [SIZE-1:0] data_in;
  logic            valid_write;
  logic [SIZE-1:0] data_out;
  logic            f_flag;
  logic            e_flag;
  logic            almost_full_flag;

  sync_fifo #(.SIZE(SIZE), .DEPTH(DEPTH), .READ_DIV(READ_DIV)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_in          (data_in),
    .valid_write      (valid_write),
    .data_out         (data_out),
    .f_flag           (f_flag),
    .e_flag           (e_flag),
    .almost_full_flag (almost_full_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [SIZE-1:0] q [$];
  int              mdiv;
  logic [SIZE-1:0] exp_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check("data_out", 32'(data_out), 32'(exp_dout));
    check("e_flag", 32'(e_flag), 32'(q.size() == 0));
    check("f_flag", 32'(f_flag), 32'(q.size() == DEPTH));
    check("af_flag", 32'(almost_full_flag), 32'(q.size() >= DEPTH - 1));
  endtask

  task automatic do_reset(input int cycles, input logic vw);
    @(negedge clk);
    rst         = 1'b1;
    valid_write = vw;
    data_in     = 8'hFF;
    repeat (cycles) @(posedge clk);
    #1;
    q.delete();
    mdiv     = 0;
    exp_dout = '0;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_e_flag", 32'(e_flag), 32'd1);
    check("rst_f_flag", 32'(f_flag), 32'd0);
    check("rst_af_flag", 32'(almost_full_flag), 32'd0);
  endtask

  task automatic step(input logic vw, input int v);
    logic            m_tick;
    logic            m_pop;
    logic            m_push;
    logic [SIZE-1:0] w;
    @(negedge clk);
    rst         = 1'b0;
    w           = v[SIZE-1:0];
    valid_write = vw;
    data_in     = w;
    m_tick = (mdiv == READ_DIV - 1);
    m_pop  = m_tick && (q.size() != 0);
    m_push = vw && ((q.size() != DEPTH) || m_pop);
    @(posedge clk);
    #1;
    if (m_pop) begin
      exp_dout = q.pop_front();
      check("pop_word", 32'(data_out), 32'(exp_dout));
    end
    if (m_push) q.push_back(w);
    mdiv = m_tick ? 0 : mdiv + 1;
    check_state();
  endtask

  int fill_vals [10] = '{20, 503, 90, 10, 20, 820, 30, 1, 55, 23};

  initial begin
    rst         = 1'b1;
    valid_write = 1'b0;
    data_in     = '0;
    mdiv        = 0;
    exp_dout    = '0;

    do_reset(2, 1'b0);

    // Fill and overflow straight out of reset.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, fill_vals[i]);
      if (i == 2) begin
        check("af_after_3", 32'(almost_full_flag), 32'd1);
        check("not_full_3", 32'(f_flag), 32'd0);
      end
      if (i == 3) check("full_after_4", 32'(f_flag), 32'd1);
      if (i == 4) check("first_pop", 32'(data_out), 32'd20);
    end
    check("trunc_503", 32'(data_out), 32'd247);

    // Drain to empty; last word is held afterwards.
    repeat (25) step(1'b0, 0);
    check("drain_empty", 32'(e_flag), 32'd1);
    check("drain_hold", 32'(data_out), 32'd23);

    // Keep writing while full across several ticks.
    for (int i = 0; i < 14; i++) step(1'b1, 100 + i);
    check("full_pushpop", 32'(f_flag), 32'd1);
    repeat (25) step(1'b0, 0);

    // Bursts across several pointer wraps.
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k <= 8; k++) step(1'b1, k + rep * 16);
      repeat (25) step(1'b0, 0);
    end

    // Single write exactly on an empty-state tick: no fall-through.
    for (int g = 0; g < READ_DIV && mdiv != READ_DIV - 1; g++) step(1'b0, 0);
    check("etick_align", 32'(mdiv), 32'(READ_DIV - 1));
    step(1'b1, 8'hA5);
    check("etick_nopop", 32'(data_out == 8'hA5), 32'd0);
    repeat (READ_DIV - 1) step(1'b0, 0);
    check("etick_wait", 32'(data_out == 8'hA5), 32'd0);
    step(1'b0, 0);
    check("etick_pop", 32'(data_out), 32'hA5);

    // Reset mid-operation with a write request held high.
    for (int i = 0; i < 3; i++) step(1'b1, 60 + i);
    do_reset(1, 1'b1);
    repeat (12) step(1'b0, 0);
    check("post_rst_empty", 32'(e_flag), 32'd1);
    check("post_rst_dout", 32'(data_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parameterised data FIFO with a built-in rate-limited drain. A producer pushes words with `valid_write`. The block pops one word automatically every `READ_DIV` clock cycles while it holds data, presenting it on a registered `data_out`. It sits between a fast producer and a slower fixed-rate consumer, and reports empty, full and almost-full status to the producer.

## Interface
- `SIZE`, 8 — data word width in bits.
- `DEPTH`, 4 — number of storage entries (≥2, any integer; pointers wrap at `DEPTH`).
- `READ_DIV`, 5 — drain period in clock cycles (≥1); one pop opportunity per period.

Ports:
- `clk` — in, 1 — single clock; all state updates on the rising edge.
- `rst` — in, 1 — reset is synchronous and active-high.
- `data_in` — in, `SIZE` — write data; sampled on a rising edge when `valid_write`=1.
- `valid_write` — in, 1 — push request, level-sensitive; one push per cycle while high.
- `data_out` — out, `SIZE` — registered; last popped word, held between pops.
- `f_flag` — out, 1 — full: occupancy == `DEPTH`.
- `e_flag` — out, 1 — empty: occupancy == 0.
- `almost_full_flag` — out, 1 — occupancy ≥ `DEPTH`-1 (includes full).

## Operation
- State consists of:
  - storage array of `DEPTH` × `SIZE`;
  - write pointer `wp` and read pointer `rp`, each 0..`DEPTH`-1, wrapping `DEPTH`-1 → 0;
  - occupancy `count`, 0..`DEPTH`;
  - drain divider `div`, 0..`READ_DIV`-1;
  - `data_out` register.
- Drain tick:
  - `tick` = (`div` == `READ_DIV`-1).
  - `div` increments every cycle and wraps to 0 after `READ_DIV`-1, independent of FIFO contents.
- Pop:
  - `pop` = `tick` && `count`≠0.
  - On pop: `data_out` ← mem[`rp`]; `rp` advances.
- Push:
  - `push` = `valid_write` && (`count`≠`DEPTH` || `pop`).
  - On push: mem[`wp`] ← `data_in`; `wp` advances.
- Overflow: a push request while full with no pop in the same cycle is silently dropped. Nothing is stored, and no pointer or count changes.
- Underflow: no pop while empty. A word written in the same cycle as an empty-state tick is not popped that cycle (no fall-through).
- Count update: `count` += `push` − `pop`.
  - push and pop together leave `count` unchanged.
  - On a simultaneous push+pop while full, the popped word is the oldest, and the new word lands in the freed slot.
- Flags are combinational decodes of the registered `count` only. No dependence on inputs in the same cycle.
- `data_in` wider values are the driver's concern; only `SIZE` bits exist (e.g. 503 stores as 247 for `SIZE`=8).

## Timing
- Reset (`rst`=1 at a rising edge) clears the block:
  - `wp`, `rp`, `count`, `div` = 0;
  - `data_out` = 0;
  - `e_flag`=1, `f_flag`=0, `almost_full_flag`=0.
  - Memory contents are not cleared.
- Reset has priority over push and pop in the same cycle.
- Reset mid-operation discards all stored words. The first tick after reset occurs `READ_DIV` cycles after the reset edge.
- Push at edge N:
  - `count` and flags reflect it after edge N;
  - `e_flag` falls one cycle after the first push.
- Pop latency: a word pushed at edge N appears on `data_out` at the first tick edge strictly after N.
  - Worst case `READ_DIV` cycles.
  - Best case 1 cycle, when `div`==`READ_DIV`-1 in cycle N+1.
- `data_out` changes only on pop edges or reset.
- Ordering is strict FIFO across pointer wrap-around.

## Test plan
- Reset: assert `rst` for 2 cycles with `valid_write`=0 → `data_out`=0, `e_flag`=1, `f_flag`=0, `almost_full_flag`=0; `div` restarts, and the first tick occurs 5 cycles after reset release.
- Fill/overflow (`DEPTH`=4, `READ_DIV`=5): push 20, 503, 90, 10, 20, 820, 30, 1, 55, 23 on consecutive cycles immediately after reset →
  - first pop at cycle 5 returns 20;
  - `almost_full_flag` rises after 3 net entries, `f_flag` after 4;
  - dropped words never appear;
  - 503 reads as 247 and 820 reads as 52 if accepted.
- Drain to empty: stop writing with 4 entries stored → `data_out` steps through them in order, one every 5 cycles; `f_flag` drops after the first pop; `e_flag`=1 after the 4th pop; `data_out` then holds the last value.
- Simultaneous push+pop while full: keep `valid_write` high across a tick with `count`=4 → the oldest word is output, the new word is accepted, `count` stays 4, and `f_flag` stays high.
- Wrap-around: push 0..8 in bursts with gaps longer than 4×`READ_DIV` cycles, repeated 3 times → all accepted words emerge in order across multiple pointer wraps with no duplication or loss.
- Empty-tick write: assert a single push on exactly a tick cycle with `count`=0 → no pop that cycle; the word appears on `data_out` at the next tick, 5 cycles later.
